perceptron_bht: RTL and testbench

// Perceptron direction predictor: sits beside the BTB in the frontend, consumes

---
 rtl/perceptron_bht.sv | 176 +++++++++++++++++
 tb/tb_perceptron_bht.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_bht.sv
// Perceptron branch direction predictor: combinational dot-product prediction and
// 3-state saturating trainer with a 1-entry update buffer. Define PBP_STATS_EN for counters.
package ariane_pbp_pkg;
    localparam int VLEN = 64;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;
endpackage

module perceptron_bht
    import ariane_pbp_pkg::*;
#(
    parameter int NR_ENTRIES = 64,
    parameter int HIST_LEN   = 16,
    parameter int WEIGHT_W   = 8,
    parameter int THETA      = 44
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [VLEN-1:0] vpc_i,
    input  bht_update_t     bht_update_i,
    output bht_prediction_t bht_prediction_o,
    output logic            busy_o
`ifdef PBP_STATS_EN
    ,
    output logic [15:0]     train_cnt_o,
    output logic [15:0]     drop_cnt_o
`endif
);
    localparam int IDX_W = $clog2(NR_ENTRIES);
    localparam int Y_W   = WEIGHT_W + $clog2(HIST_LEN + 1) + 1;
    localparam logic signed [Y_W-1:0] THETA_Y = Y_W'(THETA);
    localparam logic signed [Y_W-1:0] Y_ZERO  = '0;
    localparam logic [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};

    typedef logic [HIST_LEN:0][WEIGHT_W-1:0] row_t;
    typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

    row_t                  weights [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] row_valid;
    logic [HIST_LEN-1:0]   ghr;
    state_t                state;

    logic                  pend_vld, pend_taken;
    logic [IDX_W-1:0]      pend_idx;
    logic [IDX_W-1:0]      cur_idx;
    logic                  cur_taken, cur_train;
    logic [HIST_LEN-1:0]   cur_hist;

    // x_0 is the constant +1 bias input, so history is extended with a 1 at bit 0.
    function automatic logic signed [Y_W-1:0] dot(input row_t row, input logic [HIST_LEN-1:0] hist);
        logic [HIST_LEN:0]     xpos;
        logic signed [Y_W-1:0] acc;
        xpos = {hist, 1'b1};
        acc  = '0;
        for (int i = 0; i <= HIST_LEN; i++) begin
            if (xpos[i]) acc = acc + Y_W'($signed(row[i]));
            else         acc = acc - Y_W'($signed(row[i]));
        end
        return acc;
    endfunction

    logic [IDX_W-1:0]      pred_idx, upd_idx, src_idx;
    logic signed [Y_W-1:0] pred_y, cur_y;
    logic                  accept, src_taken, live_to_buf, train, up;
    logic [HIST_LEN:0]     cur_xpos;
    row_t                  cur_row, next_row;
    logic                  unused_bits;

    assign pred_idx    = vpc_i[IDX_W:1];
    assign upd_idx     = bht_update_i.pc[IDX_W:1];
    assign unused_bits = ^{vpc_i[VLEN-1:IDX_W+1], vpc_i[0],
                           bht_update_i.pc[VLEN-1:IDX_W+1], bht_update_i.pc[0]};

    always_comb begin
        pred_y = dot(weights[pred_idx], ghr);
        bht_prediction_o.valid = row_valid[pred_idx];
        bht_prediction_o.taken = row_valid[pred_idx] & (pred_y >= Y_ZERO);
    end

    // Buffered update wins; a live update that is not consumed refills the buffer only if it is free or draining.
    always_comb begin
        accept      = (state == IDLE) && (pend_vld || bht_update_i.valid);
        src_idx     = pend_vld ? pend_idx   : upd_idx;
        src_taken   = pend_vld ? pend_taken : bht_update_i.taken;
        live_to_buf = bht_update_i.valid && (pend_vld ? accept : (state != IDLE));
    end

    always_comb begin
        cur_row  = weights[cur_idx];
        cur_y    = dot(cur_row, cur_hist);
        train    = ((cur_y >= Y_ZERO) != cur_taken) || ((cur_y <= THETA_Y) && (cur_y >= -THETA_Y));
        cur_xpos = {cur_hist, 1'b1};
        next_row = cur_row;
        up       = 1'b0;
        for (int i = 0; i <= HIST_LEN; i++) begin
            up = (cur_xpos[i] == cur_taken);
            if (up) next_row[i] = (cur_row[i] == W_MAX) ? cur_row[i] : cur_row[i] + 1'b1;
            else    next_row[i] = (cur_row[i] == W_MIN) ? cur_row[i] : cur_row[i] - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) weights[i] <= '0;
            row_valid  <= '0;
            ghr        <= '0;
            state      <= IDLE;
            pend_vld   <= 1'b0;
            pend_idx   <= '0;
            pend_taken <= 1'b0;
            cur_idx    <= '0;
            cur_taken  <= 1'b0;
            cur_train  <= 1'b0;
            cur_hist   <= '0;
        end else if (flush_i) begin
            ghr      <= '0;
            state    <= IDLE;
            pend_vld <= 1'b0;
        end else begin
            if (accept) begin
                cur_idx   <= src_idx;
                cur_taken <= src_taken;
                cur_hist  <= ghr;
                ghr       <= {ghr[HIST_LEN-2:0], src_taken};
            end
            if (live_to_buf) begin
                pend_vld   <= 1'b1;
                pend_idx   <= upd_idx;
                pend_taken <= bht_update_i.taken;
            end else if (accept && pend_vld) begin
                pend_vld <= 1'b0;
            end
            case (state)
                IDLE:  if (accept) state <= CALC;
                CALC: begin
                    cur_train <= train;
                    state     <= WRITE;
                end
                WRITE: begin
                    if (cur_train) weights[cur_idx] <= next_row;
                    row_valid[cur_idx] <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o = (state != IDLE) || pend_vld;

`ifdef PBP_STATS_EN
    logic drop;
    assign drop = bht_update_i.valid && pend_vld && !accept;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            train_cnt_o <= '0;
            drop_cnt_o  <= '0;
        end else if (!flush_i) begin
            if (state == WRITE && cur_train && train_cnt_o != 16'hFFFF) train_cnt_o <= train_cnt_o + 16'd1;
            if (drop && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_perceptron_bht.sv
// Self-checking bench for perceptron_bht: directed scenarios plus random traffic
// against a timestamped transaction model of the predictor.
module tb_perceptron_bht;
    import ariane_pbp_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [VLEN-1:0] vpc;
    bht_update_t     upd;
    bht_prediction_t pred;
    logic            busy;
`ifdef PBP_STATS_EN
    logic [15:0]     train_cnt, drop_cnt;
`endif

    always #5 clk = ~clk;

    perceptron_bht dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .vpc_i(vpc),
        .bht_update_i(upd), .bht_prediction_o(pred), .busy_o(busy)
`ifdef PBP_STATS_EN
        , .train_cnt_o(train_cnt), .drop_cnt_o(drop_cnt)
`endif
    );

    // Reference model: weights as plain integers, updates tracked by the cycle they commit.
    int          mw [64][17];
    bit          mrv [64];
    logic [15:0] mghr;
    int          mcyc, mfree, mcommit;
    bit          inflight;
    int          mi_idx;
    bit          mi_tk;
    logic [15:0] mi_snap;
    bit          mp_v;
    int          mp_idx;
    bit          mp_tk;
    int          mtrains, mdrops;
    int          checks, errors;

    function automatic int ydot(input int idx, input logic [15:0] h);
        int y;
        y = mw[idx][0];
        for (int i = 1; i <= 16; i++) y += h[i-1] ? mw[idx][i] : -mw[idx][i];
        return y;
    endfunction

    task automatic apply(input int idx, input bit tk, input logic [15:0] h);
        int y, t, x;
        bit tr;
        y  = ydot(idx, h);
        tr = ((y >= 0) != tk) || (y <= 44 && y >= -44);
        if (tr) begin
            t = tk ? 1 : -1;
            for (int i = 0; i <= 16; i++) begin
                x = (i == 0) ? 1 : (h[i-1] ? 1 : -1);
                mw[idx][i] += t * x;
                if (mw[idx][i] > 127)  mw[idx][i] = 127;
                if (mw[idx][i] < -128) mw[idx][i] = -128;
            end
            if (mtrains < 65535) mtrains++;
        end
        mrv[idx] = 1;
    endtask

    task automatic model_cycle(input bit fl, input bit v, input int idx, input bit tk);
        bit idle;
        bit took_live;
        idle      = (mcyc >= mfree);
        took_live = 0;
        if (fl) begin
            inflight = 0;
            mp_v     = 0;
            mghr     = '0;
            mfree    = mcyc + 1;
        end else begin
            if (inflight && mcyc == mcommit) begin
                apply(mi_idx, mi_tk, mi_snap);
                inflight = 0;
            end
            if (idle && (mp_v || v)) begin
                if (mp_v) begin
                    mi_idx = mp_idx; mi_tk = mp_tk; mp_v = 0;
                end else begin
                    mi_idx = idx; mi_tk = tk; took_live = 1;
                end
                mi_snap  = mghr;
                mghr     = {mghr[14:0], mi_tk};
                inflight = 1;
                mcommit  = mcyc + 2;
                mfree    = mcyc + 3;
            end
            if (v && !took_live) begin
                if (!mp_v) begin
                    mp_v = 1; mp_idx = idx; mp_tk = tk;
                end else if (mdrops < 65535) begin
                    mdrops++;
                end
            end
        end
        mcyc++;
    endtask

    task automatic chk(input string tag, input integer obs, input integer exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit fl, input bit v, input logic [63:0] pc, input bit tk);
        flush     = fl;
        upd.valid = v;
        upd.pc    = pc;
        upd.taken = tk;
        model_cycle(fl, v, int'(pc[6:1]), tk);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        upd.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 64'h0, 0);
    endtask

    task automatic pred_chk(input string tag, input logic [63:0] pc);
        int  idx;
        bit  ev, et;
        vpc = pc;
        #1;
        idx = int'(pc[6:1]);
        ev  = mrv[idx];
        et  = ev && (ydot(idx, mghr) >= 0);
        chk({tag, ".valid"}, pred.valid, ev);
        chk({tag, ".taken"}, pred.taken, et);
    endtask

    task automatic state_chk(input string tag);
        chk({tag, ".busy"}, busy, (mcyc < mfree) || mp_v);
        chk({tag, ".ghr"}, dut.ghr, mghr);
`ifdef PBP_STATS_EN
        chk({tag, ".train_cnt"}, train_cnt, mtrains);
        chk({tag, ".drop_cnt"}, drop_cnt, mdrops);
`endif
    endtask

    function automatic integer wt(input int r, input int i);
        return integer'($signed(dut.weights[r][i]));
    endfunction

    initial begin
        logic [63:0] pc;
`ifdef PBP_STATS_EN
        int d0, t0;
`endif
        checks = 0; errors = 0;
        mghr = '0; mcyc = 0; mfree = 0; inflight = 0; mp_v = 0; mtrains = 0; mdrops = 0;
        rst = 1'b1; flush = 1'b0; vpc = '0; upd = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("reset.busy", busy, 0);
        chk("reset.ghr", dut.ghr, 0);
        for (int k = 0; k < 4; k++) begin
            vpc = {$urandom, $urandom};
            #1;
            chk("reset.pred", pred, 0);
        end

        // Single taken update at 0x100, visible 3 cycles after accept
        step(0, 1, 64'h100, 1);
        chk("single.busy", busy, 1);
        pred_chk("single.c1", 64'h100);
        chk("single.c1.valid0", pred.valid, 0);
        idle(1);
        chk("single.c2.valid0", pred.valid, 0);
        idle(1);
        vpc = 64'h100;
        #1;
        chk("single.c3.valid", pred.valid, 1);
        chk("single.c3.taken", pred.taken, 1);
        chk("single.ghr", dut.ghr, 16'h0001);
        chk("single.w0", wt(0, 0), 1);
        chk("single.w1", wt(0, 1), -1);
        chk("single.w16", wt(0, 16), -1);
        state_chk("single");

        // Repeated taken updates at ghr=0: training stops once y exceeds the threshold
        for (int k = 0; k < 200; k++) begin
            step(1, 0, 64'h0, 0);
            step(0, 1, 64'h100, 1);
            idle(3);
        end
        chk("repeat.w0", wt(0, 0), mw[0][0]);
        chk("repeat.w8", wt(0, 8), mw[0][8]);
        pred_chk("repeat", 64'h100);
        chk("repeat.taken", pred.taken, 1);
        state_chk("repeat");

        // Back-to-back A, B, C: A trained, B buffered, C dropped
        step(1, 0, 64'h0, 0);
`ifdef PBP_STATS_EN
        d0 = drop_cnt; t0 = train_cnt;
`endif
        step(0, 1, 64'h10, 1);
        step(0, 1, 64'h20, 0);
        chk("abc.busy_buf", busy, 1);
        step(0, 1, 64'h30, 1);
        idle(8);
        chk("abc.busy_end", busy, 0);
`ifdef PBP_STATS_EN
        chk("abc.drops", drop_cnt - d0, 1);
        chk("abc.trains", train_cnt - t0, 2);
`endif
        vpc = 64'h10; #1; chk("abc.A.valid", pred.valid, 1);
        vpc = 64'h20; #1; chk("abc.B.valid", pred.valid, 1);
        vpc = 64'h30; #1; chk("abc.C.valid", pred.valid, 0);
        state_chk("abc");

        // Flush during CALC aborts the write
        step(1, 0, 64'h0, 0);
        step(0, 1, 64'h7E, 1);
        step(1, 0, 64'h0, 0);
        chk("flush.busy", busy, 0);
        chk("flush.ghr", dut.ghr, 0);
        idle(3);
        vpc = 64'h7E; #1;
        chk("flush.A.valid", pred.valid, 0);
        chk("flush.A.w0", wt(63, 0), 0);
        state_chk("flush");

        // Sign match with |y| = THETA+1 leaves the row untouched
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 64'h0, 0);
            step(0, 1, 64'h40, 1);
            idle(3);
        end
        chk("theta.pre.w0", wt(32, 0), 3);
        chk("theta.pre.w1", wt(32, 1), -3);
        step(1, 0, 64'h0, 0);
        step(0, 1, 64'h02, 1);
        idle(3);
`ifdef PBP_STATS_EN
        t0 = train_cnt;
`endif
        step(0, 1, 64'h40, 1);
        idle(3);
        chk("theta.w0", wt(32, 0), 3);
        chk("theta.w1", wt(32, 1), -3);
        chk("theta.w5", wt(32, 5), -3);
        vpc = 64'h40; #1;
        chk("theta.valid", pred.valid, 1);
`ifdef PBP_STATS_EN
        chk("theta.trains", train_cnt - t0, 0);
`endif
        state_chk("theta");

        // Random traffic on a few aliased rows
        for (int k = 0; k < 600; k++) begin
            pc      = {$urandom, $urandom};
            pc[6:1] = 6'($urandom_range(0, 7));
            step($urandom_range(0, 31) == 0, 1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)));
            state_chk("rand");
            pc      = {$urandom, $urandom};
            pc[6:1] = 6'($urandom_range(0, 7));
            pred_chk("rand.pred", pc);
        end
        idle(6);
        for (int r = 0; r < 64; r++) begin
            chk($sformatf("final.rv[%0d]", r), dut.row_valid[r], mrv[r]);
            for (int i = 0; i <= 16; i++)
                chk($sformatf("final.w[%0d][%0d]", r, i), wt(r, i), mw[r][i]);
        end
        state_chk("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
